// File: rtl/val_downcounter.sv
// Loadable down-counter with a one-entry shadow buffer that feeds the comparator's in_x / val_is_0_check.
// Optional feature: define AUTO_RELOAD_EN to restart from the last loaded value when nothing is pending.
module val_downcounter #(
   parameter int WIDTH = 7
) (
   input  logic             counter_clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] load_val,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             dec_en,
   input  logic             abort,
   output logic [WIDTH-1:0] val,
   output logic             val_is_zero,
   output logic             done,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_ZERO  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] val_q, val_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             shadow_valid_q, shadow_valid_d;
   logic             done_q;
   logic             busy_q;
   logic             accept;
`ifdef AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   assign load_ready  = !shadow_valid_q;
   assign accept      = load_valid && load_ready;
   assign val         = val_q;
   assign val_is_zero = (val_q == '0);
   assign done        = done_q;
   assign busy        = busy_q;

   always_comb begin
      state_d        = state_q;
      val_d          = val_q;
      shadow_d       = shadow_q;
      shadow_valid_d = shadow_valid_q;
`ifdef AUTO_RELOAD_EN
      reload_d       = reload_q;
`endif
      if (abort) begin
         state_d        = ST_IDLE;
         val_d          = '0;
         shadow_d       = '0;
         shadow_valid_d = 1'b0;
`ifdef AUTO_RELOAD_EN
         reload_d       = '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  val_d   = load_val;
                  state_d = (load_val == '0) ? ST_ZERO : ST_COUNT;
`ifdef AUTO_RELOAD_EN
                  reload_d = load_val;
`endif
               end
            end
            ST_COUNT: begin
               // The nonzero guard keeps val from ever wrapping below 0.
               if (dec_en && (val_q != '0)) begin
                  val_d = val_q - WIDTH'(1);
                  if (val_q == WIDTH'(1)) begin
                     state_d = ST_ZERO;
                  end
               end
               if (accept) begin
                  shadow_d       = load_val;
                  shadow_valid_d = 1'b1;
               end
            end
            ST_ZERO: begin
               if (shadow_valid_q) begin
                  val_d          = shadow_q;
                  shadow_valid_d = 1'b0;
                  state_d        = (shadow_q == '0) ? ST_ZERO : ST_COUNT;
`ifdef AUTO_RELOAD_EN
                  reload_d       = shadow_q;
`endif
               end else if (accept) begin
                  val_d   = load_val;
                  state_d = (load_val == '0) ? ST_ZERO : ST_COUNT;
`ifdef AUTO_RELOAD_EN
                  reload_d = load_val;
`endif
               end else begin
`ifdef AUTO_RELOAD_EN
                  val_d   = reload_q;
                  state_d = (reload_q == '0) ? ST_IDLE : ST_COUNT;
`else
                  state_d = ST_IDLE;
`endif
               end
            end
            default: begin
               state_d = ST_IDLE;
               val_d   = '0;
            end
         endcase
      end
   end

   // done and busy are registered from the next state so they align with state_q.
   always_ff @(posedge counter_clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         val_q          <= '0;
         shadow_q       <= '0;
         shadow_valid_q <= 1'b0;
         done_q         <= 1'b0;
         busy_q         <= 1'b0;
`ifdef AUTO_RELOAD_EN
         reload_q       <= '0;
`endif
      end else begin
         state_q        <= state_d;
         val_q          <= val_d;
         shadow_q       <= shadow_d;
         shadow_valid_q <= shadow_valid_d;
         done_q         <= (state_d == ST_ZERO);
         busy_q         <= (state_d != ST_IDLE);
`ifdef AUTO_RELOAD_EN
         reload_q       <= reload_d;
`endif
      end
   end

endmodule

// File: tb/tb_val_downcounter.sv
// Scoreboard bench for val_downcounter: each driven cycle queues its expected post-edge outputs.
// Build with AUTO_RELOAD_EN defined to run the reload sequence instead of the default-build sequences.
module tb_val_downcounter;
   localparam int WIDTH = 7;

   logic             counter_clk = 1'b0;
   logic             reset       = 1'b0;
   logic [WIDTH-1:0] load_val    = '0;
   logic             load_valid  = 1'b0;
   logic             load_ready;
   logic             dec_en      = 1'b0;
   logic             abort       = 1'b0;
   logic [WIDTH-1:0] val;
   logic             val_is_zero;
   logic             done;
   logic             busy;

   int checks = 0;
   int errors = 0;
   int tid    = 0;
   int idx    = 0;

   typedef struct packed {
      logic [7:0]       tid;
      logic [7:0]       idx;
      logic [WIDTH-1:0] v;
      logic             d;
      logic             b;
      logic             r;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   val_downcounter #(.WIDTH(WIDTH)) dut (
      .counter_clk (counter_clk),
      .reset       (reset),
      .load_val    (load_val),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .dec_en      (dec_en),
      .abort       (abort),
      .val         (val),
      .val_is_zero (val_is_zero),
      .done        (done),
      .busy        (busy)
   );

   always #5 counter_clk = ~counter_clk;

   task automatic check_val(input string tag, input int obs, input int expv);
      checks++;
      if (obs != expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
      end
   endtask

   // Drive one cycle's inputs and queue the outputs expected after the next rising edge.
   task automatic step(input int lv, input bit lval, input bit de, input bit ab,
                       input int ev, input bit ed, input bit eb, input bit er);
      exp_t e;
      @(negedge counter_clk);
      load_val   = WIDTH'(lv);
      load_valid = lval;
      dec_en     = de;
      abort      = ab;
      e.tid = 8'(tid);
      e.idx = 8'(idx);
      e.v   = WIDTH'(ev);
      e.d   = ed;
      e.b   = eb;
      e.r   = er;
      exp_q.push_back(e);
      idx++;
      @(posedge counter_clk);
   endtask

   task automatic begin_test(input int t);
      tid = t;
      idx = 0;
   endtask

   always @(posedge counter_clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check_val($sformatf("t%0d.%0d val", mon_e.tid, mon_e.idx), int'(val), int'(mon_e.v));
         check_val($sformatf("t%0d.%0d done", mon_e.tid, mon_e.idx), int'(done), int'(mon_e.d));
         check_val($sformatf("t%0d.%0d busy", mon_e.tid, mon_e.idx), int'(busy), int'(mon_e.b));
         check_val($sformatf("t%0d.%0d load_ready", mon_e.tid, mon_e.idx), int'(load_ready), int'(mon_e.r));
         check_val($sformatf("t%0d.%0d val_is_zero", mon_e.tid, mon_e.idx), int'(val_is_zero),
                   (mon_e.v == '0) ? 1 : 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      #3;
      check_val("reset val", int'(val), 0);
      check_val("reset done", int'(done), 0);
      check_val("reset busy", int'(busy), 0);
      check_val("reset load_ready", int'(load_ready), 1);
      check_val("reset val_is_zero", int'(val_is_zero), 1);
      @(negedge counter_clk);
      reset = 1'b1;

`ifdef AUTO_RELOAD_EN
      // Reload sequence: load 2, count continuously, restarts from 2 until abort.
      begin_test(6);
      step(2, 1, 1, 0, 2, 0, 1, 1);
      repeat (2) begin
         step(0, 0, 1, 0, 1, 0, 1, 1);
         step(0, 0, 1, 0, 0, 1, 1, 1);
         step(0, 0, 1, 0, 2, 0, 1, 1);
      end
      step(0, 0, 1, 1, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0, 0, 1);
`else
      // Plain count-down of 5 then back to idle.
      begin_test(1);
      step(5, 1, 1, 0, 5, 0, 1, 1);
      for (int v = 4; v >= 1; v--) step(0, 0, 1, 0, v, 0, 1, 1);
      step(0, 0, 1, 0, 0, 1, 1, 1);
      step(0, 0, 1, 0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0, 0, 1);

      // Shadow queued at val=2; an offer while the shadow is full is dropped.
      begin_test(2);
      step(3, 1, 1, 0, 3, 0, 1, 1);
      step(0, 0, 1, 0, 2, 0, 1, 1);
      step(2, 1, 1, 0, 1, 0, 1, 0);
      step(5, 1, 1, 0, 0, 1, 1, 0);
      step(0, 0, 1, 0, 2, 0, 1, 1);
      step(0, 0, 1, 0, 1, 0, 1, 1);
      step(0, 0, 1, 0, 0, 1, 1, 1);
      step(0, 0, 1, 0, 0, 0, 0, 1);

      // Accept coinciding with the 1->0 decrement lands in the shadow.
      begin_test(7);
      step(2, 1, 1, 0, 2, 0, 1, 1);
      step(0, 0, 1, 0, 1, 0, 1, 1);
      step(3, 1, 1, 0, 0, 1, 1, 0);
      step(0, 0, 1, 0, 3, 0, 1, 1);
      step(0, 0, 1, 0, 2, 0, 1, 1);
      step(0, 0, 1, 0, 1, 0, 1, 1);
      step(0, 0, 1, 0, 0, 1, 1, 1);
      step(0, 0, 1, 0, 0, 0, 0, 1);

      // Zero loads: immediate done, no underflow, back-to-back done pulses.
      begin_test(3);
      step(0, 1, 1, 0, 0, 1, 1, 1);
      step(0, 0, 1, 0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 1, 1, 1);
      step(0, 1, 1, 0, 0, 1, 1, 1);
      step(0, 0, 1, 0, 0, 0, 0, 1);

      // Gated decrement, then abort with a load offered, then abort with shadow full.
      begin_test(4);
      step(6, 1, 1, 0, 6, 0, 1, 1);
      step(0, 0, 1, 0, 5, 0, 1, 1);
      step(0, 0, 0, 0, 5, 0, 1, 1);
      step(0, 0, 1, 0, 4, 0, 1, 1);
      step(0, 0, 0, 0, 4, 0, 1, 1);
      step(0, 0, 1, 0, 3, 0, 1, 1);
      step(9, 1, 1, 1, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0, 0, 1);
      step(4, 1, 0, 0, 4, 0, 1, 1);
      step(7, 1, 0, 0, 4, 0, 1, 0);
      step(0, 0, 1, 1, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0, 0, 1);

      // Asynchronous reset mid-count.
      begin_test(5);
      step(4, 1, 1, 0, 4, 0, 1, 1);
      step(0, 0, 1, 0, 3, 0, 1, 1);
      step(0, 0, 1, 0, 2, 0, 1, 1);
      #2;
      reset = 1'b0;
      #1;
      check_val("t5 async val", int'(val), 0);
      check_val("t5 async done", int'(done), 0);
      check_val("t5 async busy", int'(busy), 0);
      check_val("t5 async load_ready", int'(load_ready), 1);
      check_val("t5 async val_is_zero", int'(val_is_zero), 1);
      @(posedge counter_clk);
      @(negedge counter_clk);
      reset = 1'b1;
      repeat (3) step(0, 0, 1, 0, 0, 0, 0, 1);
`endif

      @(negedge counter_clk);
      check_val("queue drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
